kernel_ddr3_mem_dmaster_rl_timing_adt: RTL and testbench
========================================================

# kernel_ddr3_mem_dmaster_rl_timing_adt

Parametrised Avalon-ST timing adapter for the DDR3 debug-master byte/packet path. Converts an upstream source with ready latency IN_RL (0..3) to a standard ready-latency-0 downstream sink. A DEPTH-entry show-ahead FIFO absorbs beats still in flight when the sink backpressures. Unlike the pass-through generation, it honours downstream backpressure, drives a real `in_ready`, reports fill level, and flags both overflow and upstream protocol violations.

## Interface
Parameters:
- `DATA_W`, 8: payload width in bits.
- `IN_RL`, 1: upstream ready latency in cycles. Legal range 0..3.
- `DEPTH`, 4: FIFO entries. Must be a power of two and at least IN_RL+1; elaboration fails otherwise.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: upstream beat valid.
- `in_data`  in  DATA_W: upstream payload.
- `in_ready`  out  1: upstream may present a beat IN_RL cycles after this is sampled high.
- `out_valid`  out  1: downstream beat valid.
- `out_data`  out  DATA_W: downstream payload (FIFO head).
- `out_ready`  in  1: downstream ready, ready latency 0.
- `fill_level`  out  clog2(DEPTH+1): number of occupied entries.
- `overflow`  out  1: sticky; a beat was dropped because the FIFO was full.
- `protocol_err`  out  1: sticky; `in_valid` was asserted without the matching `in_ready`.

## Operation
- Storage: DEPTH×DATA_W register array, write pointer `wp`, read pointer `rp`, occupancy counter `cnt`.
  - Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - `cnt` ranges 0..DEPTH.
- Pop: `pop = out_valid & out_ready`. `out_valid = (cnt != 0)`. `out_data = mem[rp]`, combinational from the head.
- Push: `push = in_valid & (cnt < DEPTH | pop)`. Every `in_valid` beat is taken if storage exists; upstream is never stalled mid-beat.
- Full with simultaneous pop: the push is accepted. `cnt` is unchanged; both pointers advance.
- Drop: `in_valid` while `cnt == DEPTH` and no pop.
  - The beat is discarded.
  - `overflow` is set and stays set until `reset`.
- `cnt` update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Ready generation:
  - `in_ready = ~reset & ((DEPTH - cnt) >= IN_RL + 1)`. This is combinational from the registered `cnt`.
  - The margin covers up to IN_RL beats already in flight from earlier ready cycles.
  - With a legal upstream, overflow can therefore only result from a protocol violation.
- Ready history:
  - Shift register `rh[IN_RL:0]`, where `rh[0] = in_ready` (current) and `rh[k]` is `in_ready` from k cycles ago.
  - Legal beat condition: `in_valid` with `rh[IN_RL] == 1`. For IN_RL = 0 the condition is the current `in_ready`.
  - `in_valid` with `rh[IN_RL] == 0` sets `protocol_err` (sticky). The beat is still pushed if storage exists.
- Reset (synchronous, wins over everything): `wp = rp = cnt = 0`, `rh = 0`, `overflow = 0`, `protocol_err = 0`. Memory contents are not reset.
- Reset mid-operation: all buffered beats are discarded.

## Timing
- Output values during reset and in the first cycle after it:
  - `out_valid = 0`, `fill_level = 0`, `overflow = 0`, `protocol_err = 0`.
  - `in_ready = 0` while `reset` is high, then 1 in the first cycle after reset is released.
- Latency: a beat pushed at edge t is visible on `out_valid`/`out_data` in cycle t+1. There is no combinational in→out path.
- `in_ready` reflects `cnt` after the previous edge; a pop in the current cycle does not raise it until the next cycle.
- `fill_level` equals `cnt` (registered).
- Steady state with `out_ready` held high and continuous legal input: one beat per cycle, `cnt` stays at 1.
- After reset, `rh` is 0. Any `in_valid` within the first IN_RL cycles after reset release sets `protocol_err`.

## Test plan
- **Reset then single beat** (IN_RL=1, DEPTH=4): release reset, `in_valid` with `in_data` = 0xA5 in cycle 2 → `out_valid` = 1 and `out_data` = 0xA5 in cycle 3; `fill_level` = 1 until popped; no flags set.
- **Backpressure fill**: hold `out_ready` = 0 and stream legal beats 0x01, 0x02, …:
  - `in_ready` falls when `cnt` = 3 (DEPTH−IN_RL); `cnt` tops out at 4.
  - Releasing `out_ready` drains 0x01..0x04 in order.
  - `overflow` and `protocol_err` stay 0.
- **Full plus simultaneous push/pop**: with `cnt` = 4, assert `in_valid` (forcing the violation) and `out_ready` in the same cycle → `cnt` stays 4, the new beat becomes the tail, the next four pops are in FIFO order, and `protocol_err` = 1.
- **Overflow**: with `cnt` = 4 and `out_ready` = 0, drive `in_valid` with 0xEE → beat dropped, `overflow` = 1 (sticky); the drained data contains no 0xEE.
- **Pointer wrap** (DEPTH=4, IN_RL=0): push and pop 10 beats 0x00..0x09 with random `out_ready` → output sequence exactly 0x00..0x09 with no loss.
- **Reset mid-operation**: with `cnt` = 3, assert `reset` for one cycle → next cycle `out_valid` = 0, `fill_level` = 0, both flags cleared, and `in_ready` = 1 one cycle after release.

Source files
------------

// File: rtl/kernel_ddr3_mem_dmaster_rl_timing_adt.sv
// Ready-latency timing adapter: upstream source with ready latency IN_RL
// feeding a ready-latency-0 sink through a small show-ahead FIFO. The FIFO
// absorbs beats still in flight when the sink stalls. Fill level, a sticky
// overflow flag and a sticky upstream-protocol flag are reported.
module kernel_ddr3_mem_dmaster_rl_timing_adt #(
  parameter  int DATA_W = 8,
  parameter  int IN_RL  = 1,
  parameter  int DEPTH  = 4,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CW-1:0]     fill_level,
  output logic              overflow,
  output logic              protocol_err
);

  // Pointer width; a single-entry FIFO still needs one bit to index.
  localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  // Refuse to elaborate with an illegal latency or an undersized/odd depth.
  if (IN_RL < 0 || IN_RL > 3 || DEPTH < IN_RL + 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
    $error("kernel_ddr3_mem_dmaster_rl_timing_adt: illegal IN_RL/DEPTH combination");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wp, rp;
  logic [CW-1:0]     cnt;
  logic [IN_RL:0]    rh;      // rh[k] = in_ready from k cycles ago
  logic              pop, push, drop, late;

  // Show-ahead head: data is valid whenever anything is stored.
  assign out_valid  = (cnt != '0);
  assign out_data   = mem[rp];
  assign fill_level = cnt;

  // A full FIFO still takes a beat when the head leaves in the same cycle.
  assign pop  = out_valid & out_ready;
  assign push = in_valid & ((cnt != FULL) | pop);
  assign drop = in_valid & ~push;

  // Keep IN_RL+1 free slots so beats already in flight always fit; the
  // decision uses only registered occupancy, so a same-cycle pop does not
  // raise ready until the following cycle.
  assign in_ready = ~reset & ((32'(DEPTH) - 32'(cnt)) >= 32'(IN_RL + 1));

  // A beat is legal only if ready was high IN_RL cycles before it.
  assign late = in_valid & ~rh[IN_RL];

  if (IN_RL == 0) begin : g_rl0
    assign rh = in_ready;
  end else begin : g_rln
    logic [IN_RL-1:0] rh_q;
    // Ready history shift register; cleared so early post-reset beats are flagged.
    always_ff @(posedge clk) begin
      if (reset) rh_q <= '0;
      else       rh_q <= rh[IN_RL-1:0];
    end
    assign rh = {rh_q, in_ready};
  end

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= in_data;
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp           <= '0;
      rp           <= '0;
      cnt          <= '0;
      overflow     <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      if (push) wp <= (wp == LAST) ? '0 : wp + 1'b1;
      if (pop)  rp <= (rp == LAST) ? '0 : rp + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (drop) overflow     <= 1'b1;
      if (late) protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_kernel_ddr3_mem_dmaster_rl_timing_adt.sv
// Directed bench for the ready-latency timing adapter. A table of per-cycle
// vectors drives an IN_RL=1/DEPTH=4 instance; a second IN_RL=0 instance is
// exercised with a pointer-wrap sequence under random sink backpressure.
module tb_kernel_ddr3_mem_dmaster_rl_timing_adt;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  always #5 clk = ~clk;

  // IN_RL = 1 instance
  logic       iv = 1'b0, ordy = 1'b0;
  logic [7:0] idat = 8'h00;
  logic       ir, ov, ovf, perr;
  logic [7:0] odat;
  logic [2:0] fill;

  // IN_RL = 0 instance
  logic       iv0 = 1'b0, ordy0 = 1'b0;
  logic [7:0] idat0 = 8'h00;
  logic       ir0, ov0, ovf0, perr0;
  logic [7:0] odat0;
  logic [2:0] fill0;

  kernel_ddr3_mem_dmaster_rl_timing_adt #(.DATA_W(8), .IN_RL(1), .DEPTH(4)) u_dut (
    .clk(clk), .reset(reset), .in_valid(iv), .in_data(idat), .in_ready(ir),
    .out_valid(ov), .out_data(odat), .out_ready(ordy), .fill_level(fill),
    .overflow(ovf), .protocol_err(perr)
  );

  kernel_ddr3_mem_dmaster_rl_timing_adt #(.DATA_W(8), .IN_RL(0), .DEPTH(4)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(iv0), .in_data(idat0), .in_ready(ir0),
    .out_valid(ov0), .out_data(odat0), .out_ready(ordy0), .fill_level(fill0),
    .overflow(ovf0), .protocol_err(perr0)
  );

  typedef struct {
    logic       rst, iv;
    logic [7:0] d;
    logic       ordy;
    logic       full;   // 0: only in_ready is checked (state may be undefined/being reset)
    logic       e_ov;
    logic [7:0] e_d;
    logic [2:0] e_fill;
    logic       e_ir, e_ovf, e_perr;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nerr = 0;

  function automatic vec_t mk(logic r, logic v, logic [7:0] d, logic o, logic f,
                              logic eov, logic [7:0] ed, logic [2:0] efill,
                              logic eir, logic eovf, logic eperr);
    vec_t x;
    x.rst = r; x.iv = v; x.d = d; x.ordy = o; x.full = f;
    x.e_ov = eov; x.e_d = ed; x.e_fill = efill;
    x.e_ir = eir; x.e_ovf = eovf; x.e_perr = eperr;
    return x;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @vec %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    int sent, got, cyc;

    // reset, then single beat
    tbl.push_back(mk(1,0,8'h00,0,0, 0,8'h00,0,0,0,0));
    tbl.push_back(mk(1,0,8'h00,0,1, 0,8'h00,0,0,0,0));
    tbl.push_back(mk(0,0,8'h00,0,1, 0,8'h00,0,1,0,0));
    tbl.push_back(mk(0,1,8'hA5,0,1, 0,8'h00,0,1,0,0));
    tbl.push_back(mk(0,0,8'h00,0,1, 1,8'hA5,1,1,0,0));
    tbl.push_back(mk(0,0,8'h00,0,1, 1,8'hA5,1,1,0,0));
    tbl.push_back(mk(0,0,8'h00,1,1, 1,8'hA5,1,1,0,0));
    tbl.push_back(mk(0,0,8'h00,0,1, 0,8'h00,0,1,0,0));
    // backpressure fill, then drain in order
    tbl.push_back(mk(0,1,8'h01,0,1, 0,8'h00,0,1,0,0));
    tbl.push_back(mk(0,1,8'h02,0,1, 1,8'h01,1,1,0,0));
    tbl.push_back(mk(0,1,8'h03,0,1, 1,8'h01,2,1,0,0));
    tbl.push_back(mk(0,1,8'h04,0,1, 1,8'h01,3,0,0,0));
    tbl.push_back(mk(0,0,8'h00,0,1, 1,8'h01,4,0,0,0));
    tbl.push_back(mk(0,0,8'h00,1,1, 1,8'h01,4,0,0,0));
    tbl.push_back(mk(0,0,8'h00,1,1, 1,8'h02,3,0,0,0));
    tbl.push_back(mk(0,0,8'h00,1,1, 1,8'h03,2,1,0,0));
    tbl.push_back(mk(0,0,8'h00,1,1, 1,8'h04,1,1,0,0));
    tbl.push_back(mk(0,0,8'h00,0,1, 0,8'h00,0,1,0,0));
    // full with simultaneous push/pop (late beat -> protocol_err)
    tbl.push_back(mk(0,1,8'h11,0,1, 0,8'h00,0,1,0,0));
    tbl.push_back(mk(0,1,8'h12,0,1, 1,8'h11,1,1,0,0));
    tbl.push_back(mk(0,1,8'h13,0,1, 1,8'h11,2,1,0,0));
    tbl.push_back(mk(0,1,8'h14,0,1, 1,8'h11,3,0,0,0));
    tbl.push_back(mk(0,1,8'h15,1,1, 1,8'h11,4,0,0,0));
    tbl.push_back(mk(0,0,8'h00,0,1, 1,8'h12,4,0,0,1));
    tbl.push_back(mk(0,0,8'h00,1,1, 1,8'h12,4,0,0,1));
    tbl.push_back(mk(0,0,8'h00,1,1, 1,8'h13,3,0,0,1));
    tbl.push_back(mk(0,0,8'h00,1,1, 1,8'h14,2,1,0,1));
    tbl.push_back(mk(0,0,8'h00,1,1, 1,8'h15,1,1,0,1));
    tbl.push_back(mk(0,0,8'h00,0,1, 0,8'h00,0,1,0,1));
    // overflow: 0xEE dropped while full
    tbl.push_back(mk(0,1,8'h21,0,1, 0,8'h00,0,1,0,1));
    tbl.push_back(mk(0,1,8'h22,0,1, 1,8'h21,1,1,0,1));
    tbl.push_back(mk(0,1,8'h23,0,1, 1,8'h21,2,1,0,1));
    tbl.push_back(mk(0,1,8'h24,0,1, 1,8'h21,3,0,0,1));
    tbl.push_back(mk(0,1,8'hEE,0,1, 1,8'h21,4,0,0,1));
    tbl.push_back(mk(0,0,8'h00,0,1, 1,8'h21,4,0,1,1));
    tbl.push_back(mk(0,0,8'h00,1,1, 1,8'h21,4,0,1,1));
    tbl.push_back(mk(0,0,8'h00,1,1, 1,8'h22,3,0,1,1));
    tbl.push_back(mk(0,0,8'h00,1,1, 1,8'h23,2,1,1,1));
    tbl.push_back(mk(0,0,8'h00,1,1, 1,8'h24,1,1,1,1));
    tbl.push_back(mk(0,0,8'h00,0,1, 0,8'h00,0,1,1,1));
    // reset mid-operation with three beats buffered
    tbl.push_back(mk(0,1,8'h31,0,1, 0,8'h00,0,1,1,1));
    tbl.push_back(mk(0,1,8'h32,0,1, 1,8'h31,1,1,1,1));
    tbl.push_back(mk(0,1,8'h33,0,1, 1,8'h31,2,1,1,1));
    tbl.push_back(mk(1,0,8'h00,0,0, 0,8'h00,0,0,0,0));
    // beat in first cycle after release is early -> protocol_err
    tbl.push_back(mk(0,1,8'h40,0,1, 0,8'h00,0,1,0,0));
    tbl.push_back(mk(0,0,8'h00,1,1, 1,8'h40,1,1,0,1));
    tbl.push_back(mk(0,0,8'h00,0,1, 0,8'h00,0,1,0,1));

    @(posedge clk); #1;
    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; iv = tbl[i].iv; idat = tbl[i].d; ordy = tbl[i].ordy;
      @(negedge clk);
      nvec++;
      chk("in_ready", i, 32'(ir), 32'(tbl[i].e_ir));
      if (tbl[i].full) begin
        chk("out_valid",    i, 32'(ov),   32'(tbl[i].e_ov));
        chk("fill_level",   i, 32'(fill), 32'(tbl[i].e_fill));
        chk("overflow",     i, 32'(ovf),  32'(tbl[i].e_ovf));
        chk("protocol_err", i, 32'(perr), 32'(tbl[i].e_perr));
        if (tbl[i].e_ov) chk("out_data", i, 32'(odat), 32'(tbl[i].e_d));
      end
      @(posedge clk); #1;
    end
    iv = 1'b0; ordy = 1'b0; reset = 1'b0;

    // pointer wrap on the IN_RL=0 instance: 0x00..0x09 under random backpressure
    sent = 0; got = 0; cyc = 0;
    while (got < 10 && cyc < 300) begin
      ordy0 = 1'($urandom_range(0, 1));
      iv0   = (sent < 10) && ir0;
      idat0 = 8'(sent);
      @(negedge clk);
      if (ov0 && ordy0) begin
        nvec++;
        chk("wrap_data", got, 32'(odat0), 32'(got));
        got++;
      end
      @(posedge clk);
      if (iv0) sent++;
      #1;
      cyc++;
    end
    iv0 = 1'b0; ordy0 = 1'b0;
    if (got < 10) begin
      nerr++;
      $display("FAIL wrap_timeout: got %0d beats, expected 10", got);
    end
    @(negedge clk);
    nvec++;
    chk("wrap_fill",  0, 32'(fill0), 32'd0);
    chk("wrap_ovf",   0, 32'(ovf0),  32'd0);
    chk("wrap_perr",  0, 32'(perr0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
